// File: rtl/mips_axi_pkg.sv
// Shared types and constants for the MIPS CPU AXI-lite bridge.
package mips_axi_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    // Byte-enable count for a given data width.
    function automatic int strb_bytes(input int data_width);
        return data_width / 8;
    endfunction

    localparam int AXI_STRB_WIDTH = strb_bytes(AXI_DATA_WIDTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_RD_HOLD = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_WR_RESP = 3'd5
    } axi_state_e;

    // SLVERR and DECERR are the two responses with resp[1] set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/cpu_axi_lite_master.sv
// CPU load/store request port to AXI-lite master, one transaction in flight.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a CPU request, Mem_Req_Ack high
// ST_RD_ADDR | arvalid driven, waiting for arready
// ST_RD_DATA | rready driven, waiting for rvalid
// ST_RD_HOLD | Read_data_Valid high until the CPU acks
// ST_WR_REQ  | awvalid/wvalid driven, each drops after its own handshake
// ST_WR_RESP | bready driven, waiting for bvalid
import mips_axi_pkg::*;

module cpu_axi_lite_master #(
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXI_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    mips_cpu_reset_n,

    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic [DATA_WIDTH-1:0]   Write_data,
    input  logic [DATA_WIDTH/8-1:0] Write_strb,
    output logic                    Mem_Req_Ack,
    output logic [DATA_WIDTH-1:0]   Read_data,
    output logic                    Read_data_Valid,
    input  logic                    Read_data_Ack,
    output logic                    bus_err,

    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [2:0]              m_axi_arprot,

    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,

    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [2:0]              m_axi_awprot,

    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,

    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    axi_state_e              state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       wstrb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rdv_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic                    aw_done_q;
    logic                    w_done_q;
    logic                    bus_err_q;

    logic [ADDR_WIDTH-1:0]   addr_d;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    aw_done_d;
    logic                    w_done_d;

    // Word-align the request address and fold in this cycle's write handshakes.
    always_comb begin
        addr_d    = Address & ALIGN_MASK;
        aw_hs     = awvalid_q & m_axi_awready;
        w_hs      = wvalid_q & m_axi_wready;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
    end

    // Transaction sequencer; every AXI control output is a flop driven here.
    always_ff @(posedge clk or negedge mips_cpu_reset_n) begin
        if (!mips_cpu_reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            rdv_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A simultaneous read stays pending until the next IDLE.
                    if (MemWrite) begin
                        addr_q    <= addr_d;
                        wdata_q   <= Write_data;
                        wstrb_q   <= Write_strb;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= ST_WR_REQ;
                    end else if (MemRead) begin
                        addr_q    <= addr_d;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        rdata_q   <= m_axi_rdata;
                        rready_q  <= 1'b0;
                        rdv_q     <= 1'b1;
                        bus_err_q <= resp_is_err(m_axi_rresp);
                        state_q   <= ST_RD_HOLD;
                    end
                end
                ST_RD_HOLD: begin
                    if (Read_data_Ack) begin
                        rdv_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q  <= 1'b0;
                        bus_err_q <= resp_is_err(m_axi_bresp);
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output mapping; only Mem_Req_Ack is decoded from state.
    always_comb begin
        Mem_Req_Ack     = (state_q == ST_IDLE);
        Read_data       = rdata_q;
        Read_data_Valid = rdv_q;
        bus_err         = bus_err_q;
        m_axi_araddr    = addr_q;
        m_axi_arvalid   = arvalid_q;
        m_axi_arprot    = 3'b000;
        m_axi_rready    = rready_q;
        m_axi_awaddr    = addr_q;
        m_axi_awvalid   = awvalid_q;
        m_axi_awprot    = 3'b000;
        m_axi_wdata     = wdata_q;
        m_axi_wstrb     = wstrb_q;
        m_axi_wvalid    = wvalid_q;
        m_axi_bready    = bready_q;
    end

endmodule

// File: tb/tb_cpu_axi_lite_master.sv
// Self-checking bench: the bench plays both CPU and AXI slave, with a
// scoreboard of expected read results and write payloads.
module tb_cpu_axi_lite_master;
    import mips_axi_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [31:0]               Address;
    logic                      MemRead, MemWrite;
    logic [31:0]               Write_data;
    logic [AXI_STRB_WIDTH-1:0] Write_strb;
    logic                      Mem_Req_Ack;
    logic [31:0]               Read_data;
    logic                      Read_data_Valid, Read_data_Ack, bus_err;
    logic [31:0]               araddr, awaddr, wdata, rdata;
    logic                      arvalid, arready, rvalid, rready;
    logic                      awvalid, awready, wvalid, wready, bvalid, bready;
    logic [2:0]                arprot, awprot;
    logic [1:0]                rresp, bresp;
    logic [AXI_STRB_WIDTH-1:0] wstrb;

    typedef struct { logic [31:0] data; logic err; } rd_exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_exp_t;
    rd_exp_t rq[$];
    wr_exp_t wq[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_axi_lite_master dut (
        .clk(clk), .mips_cpu_reset_n(rst_n),
        .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
        .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ack(Mem_Req_Ack),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
        .Read_data_Ack(Read_data_Ack), .bus_err(bus_err),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_arprot(arprot),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_awprot(awprot),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input int ar_dly, input int r_dly,
                           input int ack_dly);
        logic [31:0] a_al;
        rd_exp_t     e;
        rd_exp_t     got;
        int          n;
        a_al = addr & 32'hFFFF_FFFC;
        Address = addr; MemRead = 1'b1; MemWrite = 1'b0;
        check_val("rd_req_ack", Mem_Req_Ack, 1);
        e.data = data; e.err = resp[1];
        rq.push_back(e);
        @(negedge clk);
        MemRead = 1'b0;
        check_val("rd_no_err_pending", bus_err, 0);
        check_val("rd_busy", Mem_Req_Ack, 0);
        for (int i = 0; i < ar_dly; i++) begin
            check_val("rd_arvalid_hold", arvalid, 1);
            check_val("rd_araddr_hold", araddr, a_al);
            @(negedge clk);
        end
        check_val("rd_arvalid", arvalid, 1);
        check_val("rd_araddr", araddr, a_al);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check_val("rd_arvalid_drop", arvalid, 0);
        n = 0;
        while (!rready && n < 20) begin @(negedge clk); n++; end
        check_val("rd_rready_timeout", (n < 20), 1);
        repeat (r_dly) @(negedge clk);
        rdata = data; rresp = resp; rvalid = 1'b1;
        @(negedge clk);
        rvalid = 1'b0; rdata = 32'h0; rresp = RESP_OKAY;
        check_val("rd_rready_drop", rready, 0);
        check_val("rd_valid", Read_data_Valid, 1);
        check_val("rd_bus_err", bus_err, e.err);
        if (rq.size() == 0) begin
            check_val("rd_sb_empty", 1, 0);
        end else begin
            got = rq.pop_front();
            check_val("rd_data", Read_data, got.data);
        end
        for (int i = 0; i < ack_dly; i++) begin
            if (i == 1) check_val("rd_err_pulse_width", bus_err, 0);
            MemWrite = 1'b1;
            check_val("rd_hold_valid", Read_data_Valid, 1);
            check_val("rd_hold_data", Read_data, got.data);
            check_val("rd_hold_no_ack", Mem_Req_Ack, 0);
            @(negedge clk);
            check_val("rd_hold_no_aw", awvalid, 0);
        end
        MemWrite = 1'b0;
        Read_data_Ack = 1'b1;
        @(negedge clk);
        Read_data_Ack = 1'b0;
        if (ack_dly == 0) check_val("rd_err_pulse_width", bus_err, 0);
        check_val("rd_valid_clear", Read_data_Valid, 0);
        check_val("rd_idle_ack", Mem_Req_Ack, 1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic also_read);
        wr_exp_t e;
        wr_exp_t got;
        logic    aw_seen, w_seen, hs_aw, hs_w;
        logic [31:0] cap_addr, cap_data;
        logic [3:0]  cap_strb;
        int      c, n;
        Address = addr; Write_data = data; Write_strb = strb;
        MemWrite = 1'b1; MemRead = also_read;
        check_val("wr_req_ack", Mem_Req_Ack, 1);
        e.addr = addr & 32'hFFFF_FFFC; e.data = data; e.strb = strb;
        wq.push_back(e);
        @(negedge clk);
        MemWrite = 1'b0; Write_data = ~data; Write_strb = ~strb;
        check_val("wr_no_err_pending", bus_err, 0);
        aw_seen = 1'b0; w_seen = 1'b0; c = 0;
        cap_addr = '0; cap_data = '0; cap_strb = '0;
        while (!(aw_seen && w_seen) && c < 50) begin
            check_val("wr_arvalid_off", arvalid, 0);
            check_val("wr_awvalid", awvalid, !aw_seen);
            check_val("wr_wvalid", wvalid, !w_seen);
            if (awvalid) check_val("wr_awaddr_stable", awaddr, e.addr);
            if (wvalid)  check_val("wr_wdata_stable", {wstrb, wdata}, {e.strb, e.data});
            awready = (c >= aw_dly);
            wready  = (c >= w_dly);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            if (hs_aw) cap_addr = awaddr;
            if (hs_w) begin cap_data = wdata; cap_strb = wstrb; end
            @(negedge clk);
            aw_seen = aw_seen | hs_aw;
            w_seen  = w_seen | hs_w;
            c++;
        end
        awready = 1'b0; wready = 1'b0;
        check_val("wr_hs_timeout", (c < 50), 1);
        n = 0;
        while (!bready && n < 20) begin @(negedge clk); n++; end
        check_val("wr_bready_timeout", (n < 20), 1);
        for (int i = 0; i <= b_dly; i++) begin
            check_val("wr_bready_hold", bready, 1);
            check_val("wr_valids_off", {awvalid, wvalid}, 2'b00);
            check_val("wr_resp_busy", Mem_Req_Ack, 0);
            if (i < b_dly) @(negedge clk);
        end
        bresp = resp; bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0; bresp = RESP_OKAY;
        check_val("wr_bready_drop", bready, 0);
        check_val("wr_bus_err", bus_err, resp[1]);
        check_val("wr_done_ack", Mem_Req_Ack, 1);
        if (wq.size() == 0) begin
            check_val("wr_sb_empty", 1, 0);
        end else begin
            got = wq.pop_front();
            check_val("wr_aw_payload", cap_addr, got.addr);
            check_val("wr_w_payload", {cap_strb, cap_data}, {got.strb, got.data});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        Address = '0; MemRead = 1'b0; MemWrite = 1'b0; Write_data = '0; Write_strb = '0;
        Read_data_Ack = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = RESP_OKAY;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = RESP_OKAY;
        #1;
        check_val("rst_ack", Mem_Req_Ack, 1);
        check_val("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
        check_val("rst_rdata", {Read_data_Valid, bus_err, Read_data}, 34'h0);
        check_val("rst_prot", {arprot, awprot}, 6'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // best-case read, then an unaligned read
        do_read(32'h0000_0008, 32'hDEAD_BEEF, RESP_OKAY, 0, 0, 0);
        do_read(32'h0000_0013, 32'hA5A5_0F0F, RESP_OKAY, 2, 1, 0);

        // W accepted three cycles before AW
        do_write(32'h0000_0004, 32'h0000_0041, 4'b0001, RESP_OKAY, 3, 0, 0, 1'b0);
        // best case and AW-before-W
        do_write(32'h0000_0100, 32'hCAFE_F00D, 4'b1111, RESP_OKAY, 0, 0, 0, 1'b0);
        do_write(32'h0000_0206, 32'h1122_3344, 4'b1100, RESP_OKAY, 0, 2, 2, 1'b0);

        // read and write together: the write goes first, read follows
        do_write(32'h0000_0010, 32'h0000_00AA, 4'b0011, RESP_OKAY, 1, 1, 0, 1'b1);
        do_read(32'h0000_0010, 32'h5555_AAAA, RESP_OKAY, 0, 0, 0);

        // error responses
        do_write(32'h0000_0020, 32'h0000_0077, 4'b1000, RESP_SLVERR, 0, 0, 1, 1'b0);
        do_read(32'h0000_0024, 32'h0000_1234, RESP_DECERR, 0, 0, 0);

        // CPU holds off the read data ack for five cycles
        do_read(32'h0000_0030, 32'h8765_4321, RESP_OKAY, 0, 2, 5);

        // reset while the write address/data channels are waiting
        Address = 32'h0000_0040; Write_data = 32'h0BAD_0BAD; Write_strb = 4'hF;
        MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rstmid_pending", {awvalid, wvalid}, 2'b11);
        rst_n = 1'b0;
        #1;
        check_val("rstmid_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
        check_val("rstmid_ack", Mem_Req_Ack, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rstmid_idle", {Mem_Req_Ack, awvalid, wvalid}, 3'b100);
        do_read(32'h0000_0044, 32'hFEED_FACE, RESP_OKAY, 0, 0, 0);

        check_val("sb_drained", rq.size() + wq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
